multi_ticker: RTL and testbench
===============================

# multi_ticker

Multi-channel programmable interval ticker: the parametrised successor to the single-channel ticker. It provides `CHANNELS` independent down-time counters of `WIDTH` bits. Each channel runs in one-shot or repeat mode and raises a sticky per-channel interrupt, with overrun detection. It sits beside the W5300 control logic and supplies timeouts (retransmit, link poll, socket keep-alive) from one shared instance.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent channels (1..16).
- `WIDTH`, 24: counter and threshold width in bits.
- `PRESC_W`, 8: prescaler width; used only with `MULTI_TICKER_PRESCALE_EN`.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  CHANNELS  per-channel start pulse; sampled each edge.
- `clear`  in  CHANNELS  per-channel stop and acknowledge pulse.
- `repeatable`  in  CHANNELS  mode per channel; latched at start (1 = periodic).
- `threshold`  in  CHANNELS*WIDTH  packed; channel i uses bits [i*WIDTH +: WIDTH]; latched at start.
- `presc`  in  PRESC_W  tick divider; present only with the macro defined.
- `busy`  out  CHANNELS  channel is counting.
- `irq`  out  CHANNELS  sticky expiry flag.
- `ovf`  out  CHANNELS  sticky overrun: the channel expired while `irq[i]` was already set.
- `irq_any`  out  1  OR of `irq`, registered.

## Operation
- Per-channel state machine: IDLE, RUN, DONE. Each channel has latched `thr[i]`, latched `rep[i]` and count `cnt[i]` (WIDTH bits).
- Shared `tick` enable is 1 every cycle unless the macro is defined.
- Priority per channel per edge: `clear` > `start` > expiry > count.
- `clear[i]`:
  - state goes to IDLE; `cnt`, `irq[i]` and `ovf[i]` go to 0.
  - A simultaneous `start[i]` is ignored.
- `start[i]` with threshold ≠ 0:
  - latch `thr` and `rep`; set `cnt` = 0; state goes to RUN.
  - Applies from any state, so a start in RUN restarts the channel.
  - `irq[i]` and `ovf[i]` are not touched.
- `start[i]` with threshold = 0: ignored; state unchanged.
- In RUN, on `tick`:
  - if `cnt == thr-1`, the channel expires;
  - otherwise `cnt` increments.
- Expiry:
  - `irq[i]` goes to 1.
  - If `irq[i]` was already 1, `ovf[i]` goes to 1.
  - If `rep`: `cnt` = 0 and the channel stays in RUN. Otherwise the state goes to DONE.
- DONE holds until `start` or `clear`.
- `busy[i]` = (state == RUN).
- `cnt` never wraps: it is bounded by `thr-1` ≤ 2^WIDTH−2. `thr` = 2^WIDTH−1 is legal.
- Channels are fully independent. Simultaneous events on different channels never interact.

## Timing
- Reset values: `busy` = 0, `irq` = 0, `ovf` = 0, `irq_any` = 0; all channels IDLE; `cnt` = 0; prescaler count = 0.
- Reset asserted mid-count aborts immediately and asynchronously. After release, the channel stays IDLE until a new `start`.
- `start` sampled at edge k: `busy` = 1 after edge k.
- With tick every cycle and threshold T: `irq` = 1 after edge k+T, i.e. T cycles of latency. `busy` falls at the same edge in one-shot mode.
- Repeat mode: expiries at edges k+T, k+2T, …; the period is exactly T cycles.
- T = 1: expiry at edge k+1, then every cycle in repeat mode.
- `clear` sampled at edge c: `irq`/`busy`/`ovf` = 0 after edge c.
- `clear` and expiry on the same edge: `clear` wins and `irq` stays 0.
- `irq_any` lags `irq` by one cycle.
- `start`/`clear` are single-cycle pulses from the user. A level held high is re-applied every edge; for `start` this keeps restarting the count.

## Configuration
- `MULTI_TICKER_PRESCALE_EN` defined:
  - Adds the `presc` port and a free-running shared counter `pcnt` (0..presc).
  - `tick` = (`pcnt == presc`); `pcnt` wraps to 0 on tick.
  - The unit period becomes presc+1 cycles. Time to the first expiry after start is between (T−1)(presc+1)+1 and T(presc+1) cycles, because phase is not aligned.
  - `presc` = 0 is equivalent to no prescaler.
  - Changing `presc` takes effect at the next compare.
- Undefined: no `presc` port, no prescaler logic, `tick` = 1 constant.

## Test plan
Use CHANNELS=4, WIDTH=24, no prescaler unless stated.
- Reset: assert `rst` mid-run → all outputs 0 immediately. After release, no activity without `start`.
- One-shot: ch0 `threshold`=200, `start` pulse at edge k → `busy[0]` for 200 cycles, `irq[0]`=1 after edge k+200, `irq_any` at k+201, state DONE. `clear[0]` → `irq[0]`=0.
- Repeat overrun: ch1 T=5, `repeatable`=1, no clear → `irq[1]` at k+5, `ovf[1]` at k+10, `busy[1]` stays 1. `clear[1]` → all flags 0 and `busy[1]`=0.
- Collisions:
  - `clear[2]` on the expiry edge → `irq[2]`=0.
  - `start`+`clear` on the same edge → IDLE.
  - `threshold`=0 start → ignored.
  - Restart of ch3 at cnt=50 with T=100 → expiry 100 cycles after the restart.
- Independence: ch0..ch3 with T=3,7,11,13 started on the same edge → each `irq[i]` at exactly k+T.
- Prescaler (macro defined, `presc`=3, T=4) → first expiry 13..16 cycles after start; repeat period 16 cycles.

Source files
------------

// File: rtl/multi_ticker.sv
// rtl/multi_ticker.sv - multi-channel programmable interval ticker (one-shot/repeat, sticky irq/ovf)
// Optional prescaler enabled by defining MULTI_TICKER_PRESCALE_EN.
module multi_ticker #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 24,
    parameter int PRESC_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS-1:0]       repeatable,
    input  logic [CHANNELS*WIDTH-1:0] threshold,
`ifdef MULTI_TICKER_PRESCALE_EN
    input  logic [PRESC_W-1:0]        presc,
`endif
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       irq,
    output logic [CHANNELS-1:0]       ovf,
    output logic                      irq_any
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q [CHANNELS];
    state_t               state_d [CHANNELS];
    logic [WIDTH-1:0]     cnt_q   [CHANNELS];
    logic [WIDTH-1:0]     cnt_d   [CHANNELS];
    logic [WIDTH-1:0]     thr_q   [CHANNELS];
    logic [WIDTH-1:0]     thr_d   [CHANNELS];
    logic [CHANNELS-1:0]  rep_q, rep_d;
    logic [CHANNELS-1:0]  irq_q, irq_d;
    logic [CHANNELS-1:0]  ovf_q, ovf_d;
    logic                 irq_any_q, irq_any_d;
    logic                 tick;

`ifdef MULTI_TICKER_PRESCALE_EN
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;

    // >= rather than == so that lowering presc below the running count wraps at once
    always_comb begin
        tick   = (pcnt_q >= presc);
        pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
                thr_q[i]   <= '0;
            end
            rep_q     <= '0;
            irq_q     <= '0;
            ovf_q     <= '0;
            irq_any_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                thr_q[i]   <= thr_d[i];
            end
            rep_q     <= rep_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
            irq_any_q <= irq_any_d;
        end
    end

    // Per-channel priority: clear > start > expiry > count
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        thr_d     = thr_q;
        rep_d     = rep_q;
        irq_d     = irq_q;
        ovf_d     = ovf_q;
        irq_any_d = |irq_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (clear[i]) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
                irq_d[i]   = 1'b0;
                ovf_d[i]   = 1'b0;
            end else if (start[i] && (threshold[i*WIDTH +: WIDTH] != '0)) begin
                state_d[i] = S_RUN;
                cnt_d[i]   = '0;
                thr_d[i]   = threshold[i*WIDTH +: WIDTH];
                rep_d[i]   = repeatable[i];
            end else if ((state_q[i] == S_RUN) && tick) begin
                if (cnt_q[i] == thr_q[i] - WIDTH'(1)) begin
                    irq_d[i] = 1'b1;
                    ovf_d[i] = ovf_q[i] | irq_q[i];
                    cnt_d[i] = '0;
                    if (!rep_q[i]) begin
                        state_d[i] = S_DONE;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i] = (state_q[i] == S_RUN);
        end
        irq     = irq_q;
        ovf     = ovf_q;
        irq_any = irq_any_q;
    end

endmodule

// File: tb/tb_multi_ticker.sv
// tb/tb_multi_ticker.sv - scoreboard bench for multi_ticker (prescaler test with MULTI_TICKER_PRESCALE_EN)
module tb_multi_ticker;

    localparam int CH = 4;
    localparam int W  = 24;
    localparam int PW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   start = '0;
    logic [CH-1:0]   clear = '0;
    logic [CH-1:0]   repeatable = '0;
    logic [CH*W-1:0] threshold = '0;
`ifdef MULTI_TICKER_PRESCALE_EN
    logic [PW-1:0]   presc = '0;
`endif
    logic [CH-1:0]   busy, irq, ovf;
    logic            irq_any;

    multi_ticker #(.CHANNELS(CH), .WIDTH(W), .PRESC_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear      (clear),
        .repeatable (repeatable),
        .threshold  (threshold),
`ifdef MULTI_TICKER_PRESCALE_EN
        .presc      (presc),
`endif
        .busy       (busy),
        .irq        (irq),
        .ovf        (ovf),
        .irq_any    (irq_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_n;
        int ch;
        int kind;
    } ev_t;

    ev_t           exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            ecount = 0;
    bit            sb_off = 1'b0;
    logic [CH-1:0] pirq = '0;
    logic [CH-1:0] povf = '0;

    // Advance one clock edge, then compare rising irq/ovf against the scoreboard
    task automatic step();
        ev_t  e;
        logic rise;
        @(posedge clk);
        @(negedge clk);
        ecount++;
        for (int c = 0; c < CH; c++) begin
            for (int kd = 0; kd < 2; kd++) begin
                rise = (kd == 0) ? (irq[c] && !pirq[c]) : (ovf[c] && !povf[c]);
                if (rise && !sb_off) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected ch=%0d kind=%0d edge=%0d required=none", c, kd, ecount);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.edge_n !== ecount || e.ch !== c || e.kind !== kd) begin
                            bad++;
                            $display("FAIL sb_event got ch=%0d kind=%0d edge=%0d required ch=%0d kind=%0d edge=%0d",
                                     c, kd, ecount, e.ch, e.kind, e.edge_n);
                        end
                    end
                end
            end
        end
        pirq = irq;
        povf = ovf;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic drain(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending=%0d required=0 next_edge=%0d", name, exp_q.size(), exp_q[0].edge_n);
            exp_q.delete();
        end
    endtask

    task automatic push(input int edge_n, input int ch, input int kind);
        ev_t e;
        e.edge_n = edge_n;
        e.ch     = ch;
        e.kind   = kind;
        exp_q.push_back(e);
    endtask

    task automatic arm(input int ch, input int t, input bit rep);
        threshold[ch*W +: W] = W'(t);
        repeatable[ch] = rep;
        start[ch] = 1'b1;
        step();
        start[ch] = 1'b0;
    endtask

    task automatic do_clear(input logic [CH-1:0] m);
        clear = m;
        step();
        clear = '0;
    endtask

    task automatic test_reset();
        steps(2);
        total++;
        if ({busy, irq, ovf, irq_any} !== '0) begin
            bad++;
            $display("FAIL reset_values got=%h required=0", {busy, irq, ovf, irq_any});
        end
        rst = 1'b0;
        arm(0, 1000, 1'b0);
        steps(5);
        total++;
        if (busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_prerun_busy got=%b required=1", busy[0]);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, irq, ovf, irq_any} !== '0) begin
            bad++;
            $display("FAIL reset_async got=%h required=0", {busy, irq, ovf, irq_any});
        end
        steps(2);
        rst = 1'b0;
        steps(20);
        total++;
        if ({busy, irq} !== '0) begin
            bad++;
            $display("FAIL reset_idle_after got=%h required=0", {busy, irq});
        end
    endtask

    task automatic test_oneshot();
        int k;
        int hi;
        k = ecount + 1;
        push(k + 200, 0, 0);
        arm(0, 200, 1'b0);
        hi = busy[0] ? 1 : 0;
        repeat (199) begin
            step();
            if (busy[0]) hi++;
        end
        total++;
        if (hi !== 200) begin
            bad++;
            $display("FAIL oneshot_busy_cycles got=%0d required=200", hi);
        end
        step();
        total++;
        if ({busy[0], irq[0], irq_any} !== 3'b010) begin
            bad++;
            $display("FAIL oneshot_expiry_edge busy,irq,irq_any got=%b required=010", {busy[0], irq[0], irq_any});
        end
        step();
        total++;
        if (irq_any !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_irq_any_lag got=%b required=1", irq_any);
        end
        drain("oneshot_pending");
        do_clear(4'b0001);
        total++;
        if (irq[0] !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_clear got=%b required=0", irq[0]);
        end
        step();
        total++;
        if (irq_any !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_irq_any_clear got=%b required=0", irq_any);
        end
    endtask

    task automatic test_repeat_overrun();
        int k;
        k = ecount + 1;
        push(k + 5, 1, 0);
        push(k + 10, 1, 1);
        arm(1, 5, 1'b1);
        steps(11);
        total++;
        if ({busy[1], irq[1], ovf[1]} !== 3'b111) begin
            bad++;
            $display("FAIL repeat_flags busy,irq,ovf got=%b required=111", {busy[1], irq[1], ovf[1]});
        end
        drain("repeat_pending");
        do_clear(4'b0010);
        repeatable[1] = 1'b0;
        total++;
        if ({busy[1], irq[1], ovf[1]} !== 3'b000) begin
            bad++;
            $display("FAIL repeat_clear got=%b required=000", {busy[1], irq[1], ovf[1]});
        end
    endtask

    task automatic test_t1();
        int k;
        k = ecount + 1;
        push(k + 1, 0, 0);
        push(k + 2, 0, 1);
        arm(0, 1, 1'b1);
        steps(3);
        total++;
        if (busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL t1_busy got=%b required=1", busy[0]);
        end
        drain("t1_pending");
        do_clear(4'b0001);
        repeatable[0] = 1'b0;
    endtask

    task automatic test_collisions();
        int k;
        int r;
        arm(2, 10, 1'b0);
        steps(9);
        do_clear(4'b0100);
        total++;
        if ({busy[2], irq[2]} !== 2'b00) begin
            bad++;
            $display("FAIL coll_clear_on_expiry busy,irq got=%b required=00", {busy[2], irq[2]});
        end
        threshold[2*W +: W] = W'(10);
        start[2] = 1'b1;
        clear[2] = 1'b1;
        step();
        start[2] = 1'b0;
        clear[2] = 1'b0;
        total++;
        if (busy[2] !== 1'b0) begin
            bad++;
            $display("FAIL coll_start_clear got=%b required=0", busy[2]);
        end
        steps(12);
        arm(2, 0, 1'b0);
        total++;
        if (busy[2] !== 1'b0) begin
            bad++;
            $display("FAIL coll_zero_thr_idle got=%b required=0", busy[2]);
        end
        k = ecount + 1;
        push(k + 20, 3, 0);
        arm(3, 20, 1'b0);
        steps(4);
        arm(3, 0, 1'b0);
        steps(15);
        drain("coll_zero_thr_running");
        do_clear(4'b1000);
        arm(3, 100, 1'b0);
        steps(50);
        r = ecount + 1;
        push(r + 100, 3, 0);
        arm(3, 100, 1'b0);
        steps(100);
        total++;
        if ({busy[3], irq[3]} !== 2'b01) begin
            bad++;
            $display("FAIL coll_restart busy,irq got=%b required=01", {busy[3], irq[3]});
        end
        drain("coll_restart_pending");
        do_clear(4'b1000);
    endtask

    task automatic test_independence();
        int k;
        int tv[4] = '{3, 7, 11, 13};
        k = ecount + 1;
        for (int c = 0; c < CH; c++) begin
            push(k + tv[c], c, 0);
            threshold[c*W +: W] = W'(tv[c]);
        end
        repeatable = '0;
        start = '1;
        step();
        start = '0;
        steps(13);
        total++;
        if ({busy, irq} !== 8'h0F) begin
            bad++;
            $display("FAIL indep_final busy,irq got=%h required=0f", {busy, irq});
        end
        drain("indep_pending");
        do_clear('1);
    endtask

    task automatic test_back_to_back();
        int k;
        k = ecount + 1;
        push(k + 4, 0, 0);
        arm(0, 4, 1'b0);
        steps(4);
        k = ecount + 1;
        push(k + 4, 0, 1);
        arm(0, 4, 1'b0);
        steps(4);
        total++;
        if ({busy[0], irq[0], ovf[0]} !== 3'b011) begin
            bad++;
            $display("FAIL b2b_flags busy,irq,ovf got=%b required=011", {busy[0], irq[0], ovf[0]});
        end
        drain("b2b_pending");
        do_clear(4'b0001);
    endtask

`ifdef MULTI_TICKER_PRESCALE_EN
    task automatic test_prescale();
        int k;
        int e1;
        int e2;
        sb_off = 1'b1;
        presc = 8'd3;
        k = ecount + 1;
        arm(0, 4, 1'b1);
        for (int n = 0; n < 40 && !irq[0]; n++) step();
        e1 = ecount;
        total++;
        if (!irq[0] || (e1 - k) < 13 || (e1 - k) > 16) begin
            bad++;
            $display("FAIL presc_first_latency got=%0d irq=%b required=13..16", e1 - k, irq[0]);
        end
        for (int n = 0; n < 40 && !ovf[0]; n++) step();
        e2 = ecount;
        total++;
        if (!ovf[0] || (e2 - e1) !== 16) begin
            bad++;
            $display("FAIL presc_period got=%0d ovf=%b required=16", e2 - e1, ovf[0]);
        end
        do_clear(4'b0001);
        repeatable[0] = 1'b0;
        presc = '0;
        sb_off = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_repeat_overrun();
        test_t1();
        test_collisions();
        test_independence();
        test_back_to_back();
`ifdef MULTI_TICKER_PRESCALE_EN
        test_prescale();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
